// File: rtl/coax_pkg.sv
// Shared coax line constants and FSM encoding, common to the transmit and receive sides.
package coax_pkg;

  localparam int unsigned WORD_W           = 10;
  localparam int unsigned QUIESCE_BITS     = 5;
  localparam int unsigned VIOLATION_HALVES = 3;
  localparam int unsigned END_HALVES       = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_VIOLATION,
    ST_SYNC,
    ST_DATA,
    ST_PARITY,
    ST_END
  } coax_state_e;

  // Index of the final half-bit spent in each line state.
  function automatic logic [4:0] last_half(input coax_state_e st);
    case (st)
      ST_QUIESCE:   return 5'(2 * QUIESCE_BITS - 1);
      ST_VIOLATION: return 5'(2 * VIOLATION_HALVES - 1);
      ST_SYNC:      return 5'd1;
      ST_DATA:      return 5'(2 * WORD_W - 1);
      ST_PARITY:    return 5'd1;
      ST_END:       return 5'(END_HALVES - 1);
      default:      return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Half-bit tick generator: pulses every CLOCKS_PER_BIT/2 cycles while enabled.
module coax_tx_bit_timer #(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick,
  output logic second
);

  localparam int unsigned HALF = CLOCKS_PER_BIT / 2;
  localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      second <= 1'b0;
    end else if (!enable) begin
      cnt    <= '0;
      second <= 1'b0;
    end else if (tick) begin
      cnt    <= '0;
      second <= ~second;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/coax_tx_word_serializer.sv
// Coax transmit serializer: one-word holding buffer feeding a Manchester frame FSM.
module coax_tx_word_serializer
  import coax_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              tx,
  output logic              active
);

  coax_state_e       state;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] shreg;
  logic              hold_full;
  logic              par;
  logic [4:0]        hcnt;
  logic              tick;
  logic              second;
  logic              timer_en;
  logic              last;
  logic              enter_sync;

  assign timer_en = (state != ST_IDLE);
  assign ready    = ~hold_full;

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (timer_en),
    .tick   (tick),
    .second (second)
  );

  always_comb begin
    last       = tick && (hcnt == last_half(state));
    enter_sync = last && ((state == ST_VIOLATION) || (state == ST_PARITY && hold_full));
  end

  // tx is registered and always holds the level of the half-bit currently on the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      tx        <= 1'b0;
      active    <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      par       <= 1'b0;
      hcnt      <= '0;
    end else begin
      if (valid && !hold_full) begin
        hold      <= data;
        hold_full <= 1'b1;
      end

      if (state == ST_IDLE) begin
        if (hold_full) begin
          state  <= ST_QUIESCE;
          active <= 1'b1;
          tx     <= 1'b0;
          hcnt   <= '0;
        end
      end else if (last) begin
        hcnt <= '0;
        case (state)
          ST_QUIESCE:   begin state <= ST_VIOLATION; tx <= 1'b0; end
          ST_VIOLATION: begin state <= ST_SYNC;      tx <= 1'b0; end
          ST_SYNC:      begin state <= ST_DATA;      tx <= ~shreg[WORD_W-1]; end
          ST_DATA:      begin state <= ST_PARITY;    tx <= ~par; end
          ST_PARITY: begin
            if (hold_full) begin
              state <= ST_SYNC;
              tx    <= 1'b0;
            end else begin
              state <= ST_END;
              tx    <= 1'b1;
            end
          end
          default: begin
            state  <= ST_IDLE;
            tx     <= 1'b0;
            active <= 1'b0;
          end
        endcase
      end else if (tick) begin
        hcnt <= hcnt + 5'd1;
        case (state)
          ST_VIOLATION: tx <= (hcnt >= 5'(VIOLATION_HALVES - 1));
          ST_DATA: begin
            if (second) begin
              shreg <= shreg << 1;
              tx    <= ~shreg[WORD_W-2];
            end else begin
              tx <= shreg[WORD_W-1];
            end
          end
          ST_END:  tx <= 1'b1;
          default: tx <= ~tx;
        endcase
      end

      // Holding and shift registers never collide: acceptance needs the holding register empty.
      if (enter_sync) begin
        shreg     <= hold;
        par       <= ^hold;
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_coax_tx_word_serializer.sv
// Directed bench for coax_tx_word_serializer at CLOCKS_PER_BIT 8 and 4.
module tb_coax_tx_word_serializer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] data;
  logic       valid;
  logic       sel4;
  logic       valid8, valid4;
  logic       ready8, ready4, tx8, tx4, active8, active4;
  logic       obs_tx, obs_active, obs_ready;

  int tests = 0;
  int fails = 0;
  int hc;
  int exp_n;
  logic exp_tx  [0:511];
  logic exp_act [0:511];
  logic rec_tx  [0:511];
  logic rec_act [0:511];
  logic rec_rdy [0:511];

  assign valid8     = valid & ~sel4;
  assign valid4     = valid & sel4;
  assign obs_tx     = sel4 ? tx4 : tx8;
  assign obs_active = sel4 ? active4 : active8;
  assign obs_ready  = sel4 ? ready4 : ready8;

  coax_tx_word_serializer #(.CLOCKS_PER_BIT(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .data(data), .valid(valid8),
    .ready(ready8), .tx(tx8), .active(active8)
  );

  coax_tx_word_serializer #(.CLOCKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .data(data), .valid(valid4),
    .ready(ready4), .tx(tx4), .active(active4)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- expected waveform construction ----------------
  task automatic add_half(input logic lvl, input logic act);
    for (int i = 0; i < hc; i++) begin
      exp_tx[exp_n]  = lvl;
      exp_act[exp_n] = act;
      exp_n++;
    end
  endtask

  task automatic add_bit(input logic b);
    add_half(~b, 1'b1);
    add_half(b, 1'b1);
  endtask

  task automatic add_preamble();
    for (int i = 0; i < 5; i++) add_bit(1'b1);
    for (int i = 0; i < 3; i++) add_half(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add_half(1'b1, 1'b1);
  endtask

  task automatic add_word(input logic [9:0] w, input logic p);
    add_bit(1'b1);
    for (int i = 9; i >= 0; i--) add_bit(w[i]);
    add_bit(p);
  endtask

  task automatic add_end();
    for (int i = 0; i < 4; i++) add_half(1'b1, 1'b1);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      exp_tx[exp_n]  = 1'b0;
      exp_act[exp_n] = 1'b0;
      exp_n++;
    end
  endtask

  // ---------------- stimulus / capture ----------------
  task automatic offer_word(input logic [9:0] w, input bit drop, output bit ok);
    data  = w;
    valid = 1'b1;
    ok    = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (obs_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    if (drop) valid = 1'b0;
  endtask

  task automatic record_window(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (obs_active) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (ok) begin
      for (int i = 0; i < exp_n; i++) begin
        rec_tx[i]  = obs_tx;
        rec_act[i] = obs_active;
        rec_rdy[i] = obs_ready;
        step();
      end
    end
  endtask

  task automatic scan(output int bad, output int act_cnt);
    bad = -1;
    act_cnt = 0;
    for (int i = 0; i < exp_n; i++) begin
      if (rec_act[i]) act_cnt++;
      if (bad < 0 && (rec_tx[i] !== exp_tx[i] || rec_act[i] !== exp_act[i])) bad = i;
    end
  endtask

  task automatic run_single_frame(input logic [9:0] w, input logic p,
                                  output bit acc_ok, output bit rise_ok,
                                  output int bad, output int act_cnt);
    exp_n = 0;
    add_preamble();
    add_word(w, p);
    add_end();
    add_idle(4);
    fork
      offer_word(w, 1'b1, acc_ok);
      record_window(rise_ok);
    join
    scan(bad, act_cnt);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sel4 = 1'b0; valid = 1'b0; data = '0; reset_n = 1'b0;
    repeat (3) step();
    tests++; if (tx8 !== 1'b0) begin fails++; $display("FAIL reset_tx: got %b, want 0", tx8); end
    tests++; if (active8 !== 1'b0) begin fails++; $display("FAIL reset_active: got %b, want 0", active8); end
    tests++; if (ready8 !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b, want 1", ready8); end
    tests++; if (ready4 !== 1'b1) begin fails++; $display("FAIL reset_ready4: got %b, want 1", ready4); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    bit acc_ok, rise_ok; int bad, cnt;
    sel4 = 1'b0; hc = 4;
    run_single_frame(10'h2AA, 1'b1, acc_ok, rise_ok, bad, cnt);
    tests++; if (acc_ok !== 1'b1 || rise_ok !== 1'b1) begin fails++; $display("FAIL single_handshake: accept=%b rise=%b, want 1 1", acc_ok, rise_ok); end
    tests++; if (bad !== -1) begin fails++; $display("FAIL single_wave sample %0d: tx=%b active=%b, want tx=%b active=%b", bad, rec_tx[bad], rec_act[bad], exp_tx[bad], exp_act[bad]); end
    tests++; if (cnt !== 176) begin fails++; $display("FAIL single_active_len: got %0d cycles, want 176", cnt); end
    tests++; if (rec_tx[176] !== 1'b0) begin fails++; $display("FAIL single_idle_tx: got %b, want 0", rec_tx[176]); end
    tests++; if (rec_rdy[63] !== 1'b0) begin fails++; $display("FAIL single_ready_pre_sync: got %b, want 0", rec_rdy[63]); end
    tests++; if (rec_rdy[64] !== 1'b1) begin fails++; $display("FAIL single_ready_post_sync: got %b, want 1", rec_rdy[64]); end
  endtask

  task automatic test_zero_word();
    bit acc_ok, rise_ok; int bad, cnt;
    sel4 = 1'b0; hc = 4;
    run_single_frame(10'h000, 1'b0, acc_ok, rise_ok, bad, cnt);
    tests++; if (acc_ok !== 1'b1 || rise_ok !== 1'b1) begin fails++; $display("FAIL zero_handshake: accept=%b rise=%b, want 1 1", acc_ok, rise_ok); end
    tests++; if (bad !== -1) begin fails++; $display("FAIL zero_wave sample %0d: tx=%b active=%b, want tx=%b active=%b", bad, rec_tx[bad], rec_act[bad], exp_tx[bad], exp_act[bad]); end
    tests++; if (cnt !== 176) begin fails++; $display("FAIL zero_active_len: got %0d cycles, want 176", cnt); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] words [3];
    logic       pars  [3];
    bit ok_all, rise_ok, ok; int bad, cnt;
    sel4 = 1'b0; hc = 4;
    words[0] = 10'h3FF; pars[0] = 1'b0;
    words[1] = 10'h155; pars[1] = 1'b1;
    words[2] = 10'h001; pars[2] = 1'b1;
    exp_n = 0;
    add_preamble();
    for (int k = 0; k < 3; k++) add_word(words[k], pars[k]);
    add_end();
    add_idle(4);
    ok_all = 1'b1;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          offer_word(words[k], (k == 2), ok);
          if (!ok) ok_all = 1'b0;
        end
      end
      record_window(rise_ok);
    join
    scan(bad, cnt);
    tests++; if (ok_all !== 1'b1 || rise_ok !== 1'b1) begin fails++; $display("FAIL b2b_handshake: accept=%b rise=%b, want 1 1", ok_all, rise_ok); end
    tests++; if (bad !== -1) begin fails++; $display("FAIL b2b_wave sample %0d: tx=%b active=%b, want tx=%b active=%b", bad, rec_tx[bad], rec_act[bad], exp_tx[bad], exp_act[bad]); end
    tests++; if (cnt !== 368) begin fails++; $display("FAIL b2b_active_len: got %0d cycles, want 368", cnt); end
  endtask

  task automatic test_end_rebuffer();
    bit ok1, ok2, rise_ok; int bad, cnt;
    sel4 = 1'b0; hc = 4;
    exp_n = 0;
    add_preamble(); add_word(10'h123, 1'b0); add_end();
    add_idle(1);
    add_preamble(); add_word(10'h007, 1'b1); add_end();
    add_idle(4);
    fork
      begin
        offer_word(10'h123, 1'b1, ok1);
        repeat (1 + 40 * 4 + 1) step();
        offer_word(10'h007, 1'b1, ok2);
      end
      record_window(rise_ok);
    join
    scan(bad, cnt);
    tests++; if (ok1 !== 1'b1 || ok2 !== 1'b1 || rise_ok !== 1'b1) begin fails++; $display("FAIL rebuf_handshake: acc1=%b acc2=%b rise=%b, want 1 1 1", ok1, ok2, rise_ok); end
    tests++; if (bad !== -1) begin fails++; $display("FAIL rebuf_wave sample %0d: tx=%b active=%b, want tx=%b active=%b", bad, rec_tx[bad], rec_act[bad], exp_tx[bad], exp_act[bad]); end
    tests++; if (cnt !== 352) begin fails++; $display("FAIL rebuf_active_len: got %0d cycles, want 352", cnt); end
  endtask

  task automatic test_mid_reset();
    bit ok, rise_ok, seen; int bad, cnt;
    sel4 = 1'b0; hc = 4;
    offer_word(10'h0F0, 1'b1, ok);
    rise_ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (obs_active) begin rise_ok = 1'b1; break; end
      step();
    end
    repeat (17 * 4) step();
    offer_word(10'h3FF, 1'b1, ok);
    repeat (10 * 4) step();
    tests++; if (ok !== 1'b1 || rise_ok !== 1'b1 || obs_ready !== 1'b0) begin fails++; $display("FAIL midrst_buffered: accept=%b rise=%b ready=%b, want 1 1 0", ok, rise_ok, obs_ready); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (obs_tx !== 1'b0 || obs_active !== 1'b0 || obs_ready !== 1'b1) begin fails++; $display("FAIL midrst_async: tx=%b active=%b ready=%b, want 0 0 1", obs_tx, obs_active, obs_ready); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (obs_active !== 1'b0 || obs_tx !== 1'b0) seen = 1'b1;
      step();
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL midrst_quiet: line activity=%b, want 0", seen); end
    exp_n = 0;
    add_preamble(); add_word(10'h2AA, 1'b1); add_end(); add_idle(4);
    data = 10'h2AA; valid = 1'b1;
    tests++; if (obs_ready !== 1'b1) begin fails++; $display("FAIL midrst_ready_before: got %b, want 1", obs_ready); end
    step();
    valid = 1'b0;
    tests++; if (obs_ready !== 1'b0) begin fails++; $display("FAIL midrst_first_accept: ready=%b, want 0", obs_ready); end
    record_window(rise_ok);
    scan(bad, cnt);
    tests++; if (rise_ok !== 1'b1 || bad !== -1) begin fails++; $display("FAIL midrst_new_frame: rise=%b first bad sample %0d, want rise 1 and -1", rise_ok, bad); end
  endtask

  task automatic test_cpb4();
    bit acc_ok, rise_ok; int bad, cnt;
    sel4 = 1'b1; hc = 2;
    run_single_frame(10'h2AA, 1'b1, acc_ok, rise_ok, bad, cnt);
    tests++; if (acc_ok !== 1'b1 || rise_ok !== 1'b1) begin fails++; $display("FAIL cpb4_handshake: accept=%b rise=%b, want 1 1", acc_ok, rise_ok); end
    tests++; if (bad !== -1) begin fails++; $display("FAIL cpb4_wave sample %0d: tx=%b active=%b, want tx=%b active=%b", bad, rec_tx[bad], rec_act[bad], exp_tx[bad], exp_act[bad]); end
    tests++; if (cnt !== 88) begin fails++; $display("FAIL cpb4_active_len: got %0d cycles, want 88", cnt); end
    sel4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_zero_word();
    test_back_to_back();
    test_end_rebuffer();
    test_mid_reset();
    test_cpb4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
